// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker: self-seeds, verifies, then free-runs and counts errors.
// Optional macro PRBS31_CHK_INVERT_EN adds rx_invert to accept an inverted line.
module prbs31_checker #(
  parameter int LOCK_CNT    = 31,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
`ifdef PRBS31_CHK_INVERT_EN
  input  logic             rx_invert,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [4:0]    FILL_LAST = 5'd30;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WIN - 1);
  localparam logic [EW-1:0] THRESH    = EW'(LOSS_THRESH);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [30:0]   hist, hist_nxt;
  logic [4:0]    fill_cnt, fill_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [WW-1:0] win_bits, win_bits_nxt;
  logic [EW-1:0] win_err, win_err_nxt;
  logic          eff_bit;
  logic          pred;
  logic          err_det;

`ifdef PRBS31_CHK_INVERT_EN
  assign eff_bit = bit_in ^ rx_invert;
`else
  assign eff_bit = bit_in;
`endif

  assign pred  = hist[27] ^ hist[30];
  assign state = state_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_SEARCH;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state_r   <= state_nxt;
      hist      <= hist_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      win_bits  <= win_bits_nxt;
      win_err   <= win_err_nxt;
      locked    <= (state_nxt == S_LOCKED);
      err_pulse <= err_det;
      // Clear wins over a coincident error; the pulse still fires.
      if (clear_cnt)
        err_count <= '0;
      else if (err_det && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state_r;
    hist_nxt     = hist;
    fill_nxt     = fill_cnt;
    match_nxt    = match_cnt;
    win_bits_nxt = win_bits;
    win_err_nxt  = win_err;
    err_det      = 1'b0;
    if (bit_valid) begin
      case (state_r)
        S_SEARCH: begin
          hist_nxt = {hist[29:0], eff_bit};
          fill_nxt = fill_cnt + 5'd1;
          if (fill_cnt == FILL_LAST) begin
            state_nxt = S_VERIFY;
            match_nxt = '0;
          end
        end
        S_VERIFY: begin
          hist_nxt = {hist[29:0], eff_bit};
          // An all-zero history is the LFSR lock-up state and never counts as a match.
          if ((eff_bit == pred) && (hist != '0)) begin
            match_nxt = match_cnt + 1'b1;
            if (match_cnt == LOCK_LAST) begin
              state_nxt    = S_LOCKED;
              win_bits_nxt = '0;
              win_err_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        S_LOCKED: begin
          hist_nxt = {hist[29:0], pred};
          err_det  = (eff_bit != pred);
          if (win_bits == WIN_LAST) begin
            win_bits_nxt = '0;
            win_err_nxt  = EW'(err_det);
          end else begin
            win_bits_nxt = win_bits + 1'b1;
            win_err_nxt  = win_err + EW'(err_det);
          end
          if (err_det && (win_err_nxt == THRESH)) begin
            state_nxt = S_SEARCH;
            fill_nxt  = '0;
          end
        end
        default: begin
          state_nxt = S_SEARCH;
          fill_nxt  = '0;
        end
      endcase
    end
  end

endmodule
